// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_pkg                                                 |
// | Purpose  : Shared op codes, FSM state encoding and flag positions  |
// |            for the sequential ALU.                                 |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package alu_pkg;

  // Operation encodings on alu_op
  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_RSV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit positions inside the packed flag register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;

endpackage
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_shift_add_mul                                       |
// | Purpose  : Iterative shift-add multiplier, one multiplier bit per  |
// |            clock. start loads operands; done flags the last step.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // Partial-product sum for the current step; on the last step this is the full product
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign product = acc_next;
  assign done    = (count == COUNT_LAST);

  // Operand load on start, then one shift-add step per cycle while the counter runs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      mplier <= multiplier;
      count  <= COUNT_INIT;
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - COUNT_LAST;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_seq                                                 |
// | Purpose  : Handshaked ALU with registered result and Z/C/V flags.  |
// |            Single-cycle ADD/SUB/shift ops plus an iterative MUL.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t state;
  state_t state_next;

  logic               accept;
  logic               mul_start;
  logic               single_load;
  logic               mul_finish;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic               shift_big;
  logic [WIDTH-1:0]   alu_res;
  logic [FLAG_W-1:0]  alu_flags;
  logic [FLAG_W-1:0]  mul_flags;
  logic [FLAG_W-1:0]  flags;

  alu_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (operand1),
    .multiplier   (operand2),
    .done         (mul_done),
    .product      (mul_product)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    mul_start   = 1'b0;
    single_load = 1'b0;
    mul_finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (alu_op == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_BUSY;
          end else begin
            single_load = 1'b1;
            state_next  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          mul_finish = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Single-cycle datapath: add/sub with carry, borrow and signed overflow, logical shifts
  always_comb begin
    sum       = {1'b0, operand1} + {1'b0, operand2};
    diff      = {1'b0, operand1} - {1'b0, operand2};
    add_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
    sub_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);
    // Shift amounts at or beyond WIDTH flush to zero; every bit of operand2 counts
    shift_big = (operand2 >= WIDTH_V);
    alu_res   = '0;
    alu_flags = '0;
    case (alu_op)
      OP_ADD, OP_ADDI: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_V] = add_ovf;
      end
      OP_SUB, OP_SUBI: begin
        alu_res           = diff[WIDTH-1:0];
        alu_flags[FLAG_C] = diff[WIDTH];
        alu_flags[FLAG_V] = sub_ovf;
      end
      OP_SHL: begin
        alu_res = shift_big ? '0 : (operand1 << operand2[SHW-1:0]);
      end
      OP_SHR: begin
        alu_res = shift_big ? '0 : (operand1 >> operand2[SHW-1:0]);
      end
      default: begin
        alu_res = '0;
      end
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  // Flags for a finished multiply: carry reports a nonzero upper half
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
  end

  // Output registers: written only on a completion, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (single_load) begin
      result <= alu_res;
      flags  <= alu_flags;
    end else if (mul_finish) begin
      result <= mul_product[WIDTH-1:0];
      flags  <= mul_flags;
    end
  end

  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alu_seq                                              |
// | Purpose  : Directed self-checking bench for alu_seq (WIDTH=32).    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_alu_seq;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_RSV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = 3'b000;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for out_valid; latency counts the acceptance edge as 1
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit ready_seen);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; operand1 = a; operand2 = b;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0; operand1 = $urandom; operand2 = $urandom;
    lat = 1; ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      ready_seen = ready_seen | in_ready;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Take the pending result and return to idle
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h want 0", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_err++; $display("FAIL reset zcv: got %b want 000", {flag_z, flag_c, flag_v}); end
  endtask

  task automatic test_add();
    int lat; bit rs;
    do_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat, rs);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_wrap latency: got %0d want 1", lat); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL add_wrap result: got %h want 00000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b110) begin n_err++; $display("FAIL add_wrap zcv: got %b want 110", {flag_z, flag_c, flag_v}); end
    release_out();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_wrap release in_ready: got %b want 1", in_ready); end
    do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, rs);
    n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_ovf result: got %h want 80000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b001) begin n_err++; $display("FAIL add_ovf zcv: got %b want 001", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_ADDI, 32'd5, 32'd7, lat, rs);
    n_cmp++; if (result !== 32'd12) begin n_err++; $display("FAIL addi result: got %h want 0000000c", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_err++; $display("FAIL addi zcv: got %b want 000", {flag_z, flag_c, flag_v}); end
    release_out();
  endtask

  task automatic test_sub();
    int lat; bit rs;
    do_op(OP_SUB, 32'h8000_0000, 32'h1, lat, rs);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sub_ovf latency: got %0d want 1", lat); end
    n_cmp++; if (result !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_ovf result: got %h want 7fffffff", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b001) begin n_err++; $display("FAIL sub_ovf zcv: got %b want 001", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_SUB, 32'd3, 32'd5, lat, rs);
    n_cmp++; if (result !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_borrow result: got %h want fffffffe", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin n_err++; $display("FAIL sub_borrow zcv: got %b want 010", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_SUBI, 32'd9, 32'd9, lat, rs);
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL subi_zero result: got %h want 00000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b100) begin n_err++; $display("FAIL subi_zero zcv: got %b want 100", {flag_z, flag_c, flag_v}); end
    release_out();
  endtask

  task automatic test_shift();
    int lat; bit rs;
    do_op(OP_SHL, 32'h1, 32'd31, lat, rs);
    n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL shl31 result: got %h want 80000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_err++; $display("FAIL shl31 zcv: got %b want 000", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_SHL, 32'h1, 32'd32, lat, rs);
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL shl32 result: got %h want 00000000", result); end
    n_cmp++; if (flag_z !== 1'b1) begin n_err++; $display("FAIL shl32 z: got %b want 1", flag_z); end
    release_out();
    do_op(OP_SHR, 32'h8000_0000, 32'h100, lat, rs);
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL shr256 result: got %h want 00000000", result); end
    release_out();
    do_op(OP_SHR, 32'h8000_0000, 32'd31, lat, rs);
    n_cmp++; if (result !== 32'h1) begin n_err++; $display("FAIL shr31 result: got %h want 00000001", result); end
    release_out();
    do_op(OP_SHL, 32'h0000_00F0, 32'd4, lat, rs);
    n_cmp++; if (result !== 32'h0000_0F00) begin n_err++; $display("FAIL shl4 result: got %h want 00000f00", result); end
    release_out();
  endtask

  task automatic test_reserved();
    int lat; bit rs;
    do_op(OP_RSV, 32'd5, 32'd5, lat, rs);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rsv latency: got %0d want 1", lat); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rsv result: got %h want 00000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b100) begin n_err++; $display("FAIL rsv zcv: got %b want 100", {flag_z, flag_c, flag_v}); end
    release_out();
  endtask

  task automatic test_mul();
    int lat; bit rs;
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, rs);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_hi latency: got %0d want 33", lat); end
    n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL mul_hi in_ready during busy: got %b want 0", rs); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL mul_hi result: got %h want 00000000", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b110) begin n_err++; $display("FAIL mul_hi zcv: got %b want 110", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_MUL, 32'd7, 32'd6, lat, rs);
    n_cmp++; if (result !== 32'd42) begin n_err++; $display("FAIL mul_7x6 result: got %h want 0000002a", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin n_err++; $display("FAIL mul_7x6 zcv: got %b want 000", {flag_z, flag_c, flag_v}); end
    release_out();
    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rs);
    n_cmp++; if (result !== 32'h1) begin n_err++; $display("FAIL mul_max result: got %h want 00000001", result); end
    n_cmp++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin n_err++; $display("FAIL mul_max zcv: got %b want 010", {flag_z, flag_c, flag_v}); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    do_op(OP_ADD, 32'd10, 32'd20, lat, rs);
    n_cmp++; if (result !== 32'd30) begin n_err++; $display("FAIL bp result: got %h want 0000001e", result); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; alu_op = OP_ADD; operand1 = 32'd1; operand2 = 32'd1;
      @(negedge clk);
      n_cmp++; if (result !== 32'd30) begin n_err++; $display("FAIL bp hold result cyc %0d: got %h want 0000001e", i, result); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp hold out_valid cyc %0d: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp hold in_ready cyc %0d: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp release out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    n_cmp++; if (result !== 32'd30) begin n_err++; $display("FAIL bp stable after drop: got %h want 0000001e", result); end
  endtask

  task automatic test_rst_mid_mul();
    int lat; bit rs;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; alu_op = OP_MUL; operand1 = 32'd3; operand2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mul in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mul out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_mul result: got %h want 00000000", result); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mul stray out_valid cycles: got %0d want 0", seen); end
    do_op(OP_ADD, 32'd2, 32'd2, lat, rs);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL post_rst add latency: got %0d want 1", lat); end
    n_cmp++; if (result !== 32'd4) begin n_err++; $display("FAIL post_rst add result: got %h want 00000004", result); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat; bit rs;
    out_ready = 1'b1;
    do_op(OP_ADD, 32'd1, 32'd2, lat, rs);
    n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL b2b first result: got %h want 00000003", result); end
    do_op(OP_SUB, 32'd100, 32'd1, lat, rs);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL b2b second latency: got %0d want 1", lat); end
    n_cmp++; if (result !== 32'd99) begin n_err++; $display("FAIL b2b second result: got %h want 00000063", result); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b pulse width out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'd99) begin n_err++; $display("FAIL b2b hold after take: got %h want 00000063", result); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_reserved();
    test_mul();
    test_backpressure();
    test_rst_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
